// File: rtl/expipe_pkg.sv
// rtl/expipe_pkg.sv - shared types and widths for the issue stage
package expipe_pkg;

  localparam int ROB_IDX_LEN   = 5;
  localparam int REG_NUM_DEF   = 32;
  localparam int EU_N_DEF      = 4;
  localparam int PAYLOAD_W_DEF = 64;
  localparam int REG_IDX_W     = $clog2(REG_NUM_DEF);
  localparam int EU_IDX_W      = $clog2(EU_N_DEF);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0]     rd;
    logic                     rd_we;
    logic [REG_IDX_W-1:0]     rs1;
    logic [REG_IDX_W-1:0]     rs2;
    logic [EU_IDX_W-1:0]      eu_sel;
    logic [PAYLOAD_W_DEF-1:0] payload;
  } issue_buf_t;

endpackage

// File: rtl/issue_sequencer_sat_counter.sv
// rtl/issue_sequencer_sat_counter.sv - saturating up-counter with sync clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/issue_sequencer.sv
// rtl/issue_sequencer.sv - single-entry issue stage from IQ to ROB, register status and EUs
module issue_sequencer
  import expipe_pkg::*;
#(
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int EU_N      = EU_N_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W     = 16,
  localparam int REG_IDX_LEN = $clog2(REG_NUM),
  localparam int EU_IDX_LEN  = $clog2(EU_N)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   iq_valid_i,
  output logic                   iq_ready_o,
  input  logic [REG_IDX_LEN-1:0] iq_rd_idx_i,
  input  logic                   iq_rd_we_i,
  input  logic [REG_IDX_LEN-1:0] iq_rs1_idx_i,
  input  logic [REG_IDX_LEN-1:0] iq_rs2_idx_i,
  input  logic [EU_IDX_LEN-1:0]  iq_eu_sel_i,
  input  logic [PAYLOAD_W-1:0]   iq_payload_i,
  input  logic                   rob_ready_i,
  input  logic [ROB_IDX_LEN-1:0] rob_tail_idx_i,
  output logic                   rob_valid_o,
  output logic                   rs_valid_o,
  input  logic                   rs_ready_i,
  output logic [REG_IDX_LEN-1:0] rs_rd_idx_o,
  output logic [ROB_IDX_LEN-1:0] rs_rob_idx_o,
  output logic [REG_IDX_LEN-1:0] rs_rs1_idx_o,
  output logic [REG_IDX_LEN-1:0] rs_rs2_idx_o,
  input  logic                   rs_rs1_busy_i,
  input  logic [ROB_IDX_LEN-1:0] rs_rs1_rob_idx_i,
  input  logic                   rs_rs2_busy_i,
  input  logic [ROB_IDX_LEN-1:0] rs_rs2_rob_idx_i,
  output logic [EU_N-1:0]        eu_valid_o,
  input  logic [EU_N-1:0]        eu_ready_i,
  output logic                   eu_rs1_busy_o,
  output logic [ROB_IDX_LEN-1:0] eu_rs1_rob_idx_o,
  output logic                   eu_rs2_busy_o,
  output logic [ROB_IDX_LEN-1:0] eu_rs2_rob_idx_o,
  output logic [ROB_IDX_LEN-1:0] eu_dest_rob_idx_o,
  output logic [PAYLOAD_W-1:0]   eu_payload_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  issue_state_t state_q, state_d;
  issue_buf_t   buf_q, buf_d;
  logic         wr;
  logic         fire;
  logic         accept;
  logic         stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    rob_valid_o = 1'b0;
    rs_valid_o  = 1'b0;
    eu_valid_o  = '0;

    // rd==x0 never marks anything busy, so it must not wait on register status either
    wr     = buf_q.rd_we && (buf_q.rd != '0);
    fire   = (state_q == HOLD) && !flush_i && rob_ready_i &&
             eu_ready_i[buf_q.eu_sel] && (rs_ready_i || !wr);
    iq_ready_o = !flush_i && ((state_q == EMPTY) || fire);
    accept = iq_valid_i && iq_ready_o;
    stall  = (state_q == HOLD) && !fire && !flush_i;

    if (fire) begin
      rob_valid_o                = 1'b1;
      rs_valid_o                 = wr;
      eu_valid_o[buf_q.eu_sel]   = 1'b1;
    end

    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      if (fire) begin
        state_d = EMPTY;
      end
      if (accept) begin
        state_d        = HOLD;
        buf_d.rd       = iq_rd_idx_i;
        buf_d.rd_we    = iq_rd_we_i;
        buf_d.rs1      = iq_rs1_idx_i;
        buf_d.rs2      = iq_rs2_idx_i;
        buf_d.eu_sel   = iq_eu_sel_i;
        buf_d.payload  = iq_payload_i;
      end
    end
  end

  assign rs_rd_idx_o       = buf_q.rd;
  assign rs_rob_idx_o      = rob_tail_idx_i;
  assign rs_rs1_idx_o      = buf_q.rs1;
  assign rs_rs2_idx_o      = buf_q.rs2;
  assign eu_dest_rob_idx_o = rob_tail_idx_i;
  assign eu_payload_o      = buf_q.payload;
  // x0 reads as a constant, so it is never a pending source
  assign eu_rs1_busy_o     = rs_rs1_busy_i && (buf_q.rs1 != '0);
  assign eu_rs2_busy_o     = rs_rs2_busy_i && (buf_q.rs2 != '0);
  assign eu_rs1_rob_idx_o  = rs_rs1_rob_idx_i;
  assign eu_rs2_rob_idx_o  = rs_rs2_rob_idx_i;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (stall),
    .clr   (1'b0),
    .cnt   (stall_cnt_o)
  );

endmodule

// File: tb/tb_issue_sequencer.sv
// tb/tb_issue_sequencer.sv - randomized and directed bench for issue_sequencer
module tb_issue_sequencer;

  typedef struct {
    int          rd;
    bit          we;
    int          rs1;
    int          rs2;
    int          sel;
    logic [63:0] pl;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        iq_valid_i = 1'b0;
  logic        iq_ready_o;
  logic [4:0]  iq_rd_idx_i = '0;
  logic        iq_rd_we_i = 1'b0;
  logic [4:0]  iq_rs1_idx_i = '0;
  logic [4:0]  iq_rs2_idx_i = '0;
  logic [1:0]  iq_eu_sel_i = '0;
  logic [63:0] iq_payload_i = '0;
  logic        rob_ready_i = 1'b1;
  logic [4:0]  rob_tail_idx_i = '0;
  logic        rob_valid_o;
  logic        rs_valid_o;
  logic        rs_ready_i = 1'b1;
  logic [4:0]  rs_rd_idx_o;
  logic [4:0]  rs_rob_idx_o;
  logic [4:0]  rs_rs1_idx_o;
  logic [4:0]  rs_rs2_idx_o;
  logic        rs_rs1_busy_i;
  logic [4:0]  rs_rs1_rob_idx_i;
  logic        rs_rs2_busy_i;
  logic [4:0]  rs_rs2_rob_idx_i;
  logic [3:0]  eu_valid_o;
  logic [3:0]  eu_ready_i = 4'hf;
  logic        eu_rs1_busy_o;
  logic [4:0]  eu_rs1_rob_idx_o;
  logic        eu_rs2_busy_o;
  logic [4:0]  eu_rs2_rob_idx_o;
  logic [4:0]  eu_dest_rob_idx_o;
  logic [63:0] eu_payload_o;
  logic [3:0]  stall_cnt_o;

  logic        busy_tb [32];
  logic [4:0]  rob_tb  [32];
  ins_t        held [$];
  int          cnt = 0;
  bit          wb_random = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  logic        obs_iqr, obs_rob_v, obs_rs_v, obs_b1, obs_b2;
  logic [3:0]  obs_eu_v, obs_stall;
  logic [4:0]  obs_rob_idx, obs_r1;

  assign rs_rs1_busy_i    = busy_tb[rs_rs1_idx_o];
  assign rs_rs1_rob_idx_i = rob_tb[rs_rs1_idx_o];
  assign rs_rs2_busy_i    = busy_tb[rs_rs2_idx_o];
  assign rs_rs2_rob_idx_i = rob_tb[rs_rs2_idx_o];

  always #5 clk = ~clk;

  issue_sequencer #(.CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .iq_valid_i(iq_valid_i), .iq_ready_o(iq_ready_o),
    .iq_rd_idx_i(iq_rd_idx_i), .iq_rd_we_i(iq_rd_we_i),
    .iq_rs1_idx_i(iq_rs1_idx_i), .iq_rs2_idx_i(iq_rs2_idx_i),
    .iq_eu_sel_i(iq_eu_sel_i), .iq_payload_i(iq_payload_i),
    .rob_ready_i(rob_ready_i), .rob_tail_idx_i(rob_tail_idx_i), .rob_valid_o(rob_valid_o),
    .rs_valid_o(rs_valid_o), .rs_ready_i(rs_ready_i),
    .rs_rd_idx_o(rs_rd_idx_o), .rs_rob_idx_o(rs_rob_idx_o),
    .rs_rs1_idx_o(rs_rs1_idx_o), .rs_rs2_idx_o(rs_rs2_idx_o),
    .rs_rs1_busy_i(rs_rs1_busy_i), .rs_rs1_rob_idx_i(rs_rs1_rob_idx_i),
    .rs_rs2_busy_i(rs_rs2_busy_i), .rs_rs2_rob_idx_i(rs_rs2_rob_idx_i),
    .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i),
    .eu_rs1_busy_o(eu_rs1_busy_o), .eu_rs1_rob_idx_o(eu_rs1_rob_idx_o),
    .eu_rs2_busy_o(eu_rs2_busy_o), .eu_rs2_rob_idx_o(eu_rs2_rob_idx_o),
    .eu_dest_rob_idx_o(eu_dest_rob_idx_o), .eu_payload_o(eu_payload_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_instr(input bit v, input int rd, input bit we, input int rs1,
                           input int rs2, input int sel);
    iq_valid_i   = v;
    iq_rd_idx_i  = 5'(rd);
    iq_rd_we_i   = we;
    iq_rs1_idx_i = 5'(rs1);
    iq_rs2_idx_i = 5'(rs2);
    iq_eu_sel_i  = 2'(sel);
    iq_payload_i = {$urandom, $urandom};
  endtask

  task automatic clear_model();
    held.delete();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      busy_tb[i] = 1'b0;
      rob_tb[i]  = 5'(i + 7);
    end
  endtask

  // one clock: check outputs mid-cycle against the model, then advance the model past the edge
  task automatic step();
    ins_t h;
    ins_t nw;
    bit   have, wr, fire, iqr, acc;
    @(negedge clk);
    #1;
    have = (held.size() != 0);
    h = '{rd: 0, we: 0, rs1: 0, rs2: 0, sel: 0, pl: 64'd0};
    if (have) h = held[0];
    wr   = have && h.we && (h.rd != 0);
    fire = have && !flush_i && rob_ready_i && eu_ready_i[h.sel] && (rs_ready_i || !wr);
    iqr  = !flush_i && (!have || fire);
    acc  = iq_valid_i && iqr;

    check_eq("iq_ready", iq_ready_o, iqr);
    check_eq("rob_valid", rob_valid_o, fire);
    check_eq("eu_valid", eu_valid_o, fire ? (64'd1 << h.sel) : 64'd0);
    check_eq("rs_valid", rs_valid_o, fire && wr);
    check_eq("stall_cnt", stall_cnt_o, cnt);
    if (have) begin
      check_eq("rs1_idx", rs_rs1_idx_o, h.rs1);
      check_eq("rs2_idx", rs_rs2_idx_o, h.rs2);
    end
    if (fire) begin
      check_eq("rd_idx", rs_rd_idx_o, h.rd);
      check_eq("rs_rob_idx", rs_rob_idx_o, rob_tail_idx_i);
      check_eq("dest_rob", eu_dest_rob_idx_o, rob_tail_idx_i);
      check_eq("payload", eu_payload_o, h.pl);
      check_eq("rs1_busy", eu_rs1_busy_o, (h.rs1 != 0) && busy_tb[h.rs1]);
      check_eq("rs2_busy", eu_rs2_busy_o, (h.rs2 != 0) && busy_tb[h.rs2]);
      check_eq("rs1_rob", eu_rs1_rob_idx_o, rob_tb[h.rs1]);
      check_eq("rs2_rob", eu_rs2_rob_idx_o, rob_tb[h.rs2]);
    end
    obs_iqr = iq_ready_o; obs_rob_v = rob_valid_o; obs_rs_v = rs_valid_o;
    obs_eu_v = eu_valid_o; obs_stall = stall_cnt_o; obs_rob_idx = rs_rob_idx_o;
    obs_b1 = eu_rs1_busy_o; obs_b2 = eu_rs2_busy_o; obs_r1 = eu_rs1_rob_idx_o;

    nw = '{rd: int'(iq_rd_idx_i), we: iq_rd_we_i, rs1: int'(iq_rs1_idx_i),
           rs2: int'(iq_rs2_idx_i), sel: int'(iq_eu_sel_i), pl: iq_payload_i};
    @(posedge clk);
    #1;
    if (fire) begin
      if (wr) begin
        busy_tb[h.rd] = 1'b1;
        rob_tb[h.rd]  = rob_tail_idx_i;
      end
      rob_tail_idx_i = rob_tail_idx_i + 5'd1;
    end
    if (flush_i) begin
      held.delete();
    end else begin
      if (have && !fire && cnt < 15) cnt++;
      if (fire) void'(held.pop_front());
      if (acc) held.push_back(nw);
    end
    if (wb_random && $urandom_range(0, 3) == 0) busy_tb[$urandom_range(1, 31)] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("rst_rob_valid", rob_valid_o, 0);
    check_eq("rst_eu_valid", eu_valid_o, 0);
    check_eq("rst_rs_valid", rs_valid_o, 0);
    check_eq("rst_stall", stall_cnt_o, 0);
    clear_model();
    flush_i = 0; iq_valid_i = 0;
    rob_ready_i = 1; rs_ready_i = 1; eu_ready_i = 4'hf;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    clear_model();
    do_reset();

    // reset mid-HOLD
    eu_ready_i = 4'h0;
    set_instr(1, 3, 1, 1, 2, 1);
    step();
    set_instr(0, 0, 0, 0, 0, 0);
    step(); step();
    do_reset();
    step();
    check_eq("t1_iq_ready", obs_iqr, 1);

    // three back-to-back issues, tails 5,6,7
    rob_tail_idx_i = 5'd5;
    set_instr(1, 10, 1, 1, 2, 0); step();
    set_instr(1, 11, 1, 3, 4, 1); step();
    check_eq("t2_tail0", obs_rob_idx, 5);
    set_instr(1, 12, 1, 5, 6, 3); step();
    check_eq("t2_tail1", obs_rob_idx, 6);
    set_instr(0, 0, 0, 0, 0, 0); step();
    check_eq("t2_tail2", obs_rob_idx, 7);
    check_eq("t2_eu", obs_eu_v, 4'b1000);

    // dependent pair on x5
    do_reset();
    rob_tail_idx_i = 5'd5;
    set_instr(1, 5, 1, 1, 0, 0); step();
    set_instr(1, 6, 1, 5, 5, 1); step();
    set_instr(0, 0, 0, 0, 0, 0); step();
    check_eq("t3_rob_v", obs_rob_v, 1);
    check_eq("t3_b1", obs_b1, 1);
    check_eq("t3_b2", obs_b2, 1);
    check_eq("t3_r1", obs_r1, 5);

    // rd=x0 with rd_we, rs1=x0 reported busy
    busy_tb[0] = 1'b1;
    set_instr(1, 0, 1, 0, 0, 2); step();
    set_instr(0, 0, 0, 0, 0, 0); step();
    check_eq("t4_rob_v", obs_rob_v, 1);
    check_eq("t4_rs_v", obs_rs_v, 0);
    check_eq("t4_b1", obs_b1, 0);
    busy_tb[0] = 1'b0;

    // EU 2 blocked ten cycles, then saturation
    do_reset();
    eu_ready_i = 4'b1011;
    set_instr(1, 7, 1, 2, 3, 2); step();
    set_instr(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    check_eq("t5_iq_ready", obs_iqr, 0);
    eu_ready_i = 4'hf;
    step();
    check_eq("t5_stall", obs_stall, 10);
    check_eq("t5_eu", obs_eu_v, 4'b0100);
    eu_ready_i = 4'b1011;
    set_instr(1, 8, 1, 2, 3, 2); step();
    set_instr(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step();
    check_eq("t6_sat", obs_stall, 15);

    // flush while everything is ready
    eu_ready_i = 4'hf;
    flush_i = 1; step();
    check_eq("t6_flush_eu", obs_eu_v, 0);
    check_eq("t6_flush_rob", obs_rob_v, 0);
    flush_i = 0; step();
    check_eq("t6_empty", obs_iqr, 1);
    check_eq("t6_kept", obs_stall, 15);

    // randomized traffic
    do_reset();
    wb_random = 1;
    for (int i = 0; i < 400; i++) begin
      set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 1),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3));
      flush_i     = ($urandom_range(0, 15) == 0);
      rob_ready_i = ($urandom_range(0, 3) != 0);
      rs_ready_i  = ($urandom_range(0, 3) != 0);
      eu_ready_i  = 4'($urandom);
      if (i == 200) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
